// File: rtl/cory_rdma2d_seq_pkg.sv
// Shared definitions for the 2D frame-to-line DMA command sequencers.
package cory_rdma2d_seq_pkg;

    localparam int unsigned ADDR_W = 32;   // byte address width
    localparam int unsigned RES_W  = 11;   // width/height/index field width

    // Sequencer state encoding, shared with the write-side sequencer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        EMPTY = 2'd2
    } seq_state_e;

    // Frame command payload as presented on the frame port
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [RES_W-1:0]  width;
        logic [RES_W-1:0]  height;
        logic [ADDR_W-1:0] stride;
    } frame_cmd_t;

    // Line command payload as issued to the 1D line engine
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [RES_W-1:0]  width;
        logic [RES_W-1:0]  idx;
    } line_cmd_t;

endpackage

// File: rtl/cory_posedge.sv
// Registered rising-edge detector: one-cycle pulse the cycle after d rises.
module cory_posedge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // Track previous value and register the rising-edge pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            d_q   <= d;
            pulse <= d & ~d_q;
        end
    end

endmodule

// File: rtl/cory_rdma2d_seq.sv
// 2D frame-to-line read DMA command sequencer: one line command per row.
module cory_rdma2d_seq
    import cory_rdma2d_seq_pkg::*;
#(
    parameter int unsigned A = ADDR_W,
    parameter int unsigned R = RES_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_frame_v,
    input  logic [A-1:0] i_frame_base,
    input  logic [R-1:0] i_frame_width,
    input  logic [R-1:0] i_frame_height,
    input  logic [A-1:0] i_frame_stride,
    output logic         o_frame_r,
    output logic         o_line_v,
    output logic [R-1:0] o_line_width,
    output logic [A-1:0] o_line_base,
    input  logic         i_line_r,
    output logic [R-1:0] o_line_idx,
    output logic         o_busy
);

    seq_state_e   state, state_nxt;
    logic         frame_start;
    logic         latch_c;
    logic         frame_r_c;
    logic         line_v_nxt;
    logic [A-1:0] base_nxt;
    logic [R-1:0] idx_nxt;
    logic [R-1:0] height_q;
    logic [A-1:0] stride_q;
    logic         last_c;

    // Frame start is a one-shot on a fresh frame request; masking with the
    // done pulse lets a held valid re-arm for a back-to-back frame.
    cory_posedge u_frame_start (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (i_frame_v & ~o_frame_r),
        .pulse   (frame_start)
    );

    assign last_c    = (o_line_idx == (height_q - R'(1)));
    assign o_frame_r = frame_r_c;

    // Next-state, line advance and frame-done decode
    always_comb begin
        state_nxt  = state;
        line_v_nxt = o_line_v;
        base_nxt   = o_line_base;
        idx_nxt    = o_line_idx;
        latch_c    = 1'b0;
        frame_r_c  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    latch_c = 1'b1;
                    if ((i_frame_height == '0) || (i_frame_width == '0)) begin
                        state_nxt = EMPTY;
                    end else begin
                        state_nxt  = RUN;
                        line_v_nxt = 1'b1;
                        base_nxt   = i_frame_base;
                        idx_nxt    = '0;
                    end
                end
            end
            EMPTY: begin
                frame_r_c = i_frame_v;
                state_nxt = IDLE;
            end
            RUN: begin
                if (i_line_r) begin
                    if (!i_frame_v) begin
                        line_v_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end else if (last_c) begin
                        frame_r_c  = 1'b1;
                        line_v_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end else begin
                        base_nxt = o_line_base + stride_q;
                        idx_nxt  = o_line_idx + R'(1);
                    end
                end
            end
            default: begin
                line_v_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    // State and line command registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            o_line_v    <= 1'b0;
            o_line_base <= '0;
            o_line_idx  <= '0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_line_v    <= line_v_nxt;
            o_line_base <= base_nxt;
            o_line_idx  <= idx_nxt;
            o_busy      <= (state_nxt != IDLE);
        end
    end

    // Frame geometry captured at start so the frame port may change afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_line_width <= '0;
            height_q     <= '0;
            stride_q     <= '0;
        end else if (latch_c) begin
            o_line_width <= i_frame_width;
            height_q     <= i_frame_height;
            stride_q     <= i_frame_stride;
        end
    end

endmodule
